// File: rtl/riscv_dtm_tap.sv
// RISC-V JTAG Debug Transport Module with integrated 1149.1 TAP, IDCODE/BYPASS,
// DTMCS and DMI registers, and a small DMI request FSM, all clocked by tck_i.
//
// state    | meaning
// ---------+----------------------------------------------------------
// DMI_IDLE | no access outstanding, responses accepted and discarded
// DMI_REQ  | request presented on req_*, waiting for req_ready_i
// DMI_WAIT | request accepted, waiting for resp_valid_i
module riscv_dtm_tap #(
    parameter int unsigned ABITS       = 7,
    parameter int unsigned IR_WIDTH    = 5,
    parameter logic [31:0] IDCODE_VAL  = 32'h0000_0001,
    parameter logic [2:0]  IDLE_CYCLES = 3'd1
) (
    input  logic             tck_i,
    input  logic             trst_i,
    input  logic             tms_i,
    input  logic             tdi_i,
    output logic             tdo_o,
    output logic             tdo_oe_o,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [ABITS-1:0] req_addr_o,
    output logic [31:0]      req_data_o,
    output logic [1:0]       req_op_o,
    input  logic             resp_valid_i,
    output logic             resp_ready_o,
    input  logic [31:0]      resp_data_i,
    input  logic [1:0]       resp_op_i
);

    localparam int unsigned DRW = ABITS + 34;
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(5'h10);
    localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT} dmi_state_t;

    tap_state_t tap_state, tap_next;
    dmi_state_t dmi_state;

    logic [IR_WIDTH-1:0] ir, ir_sr;
    logic [DRW-1:0]      dr;
    logic [1:0]          sticky, sticky_nxt;
    logic [31:0]         rdata;
    logic [31:0]         dtmcs_cap;
    logic [DRW-1:0]      dmi_cap;
    logic                sel_idcode, sel_dtmcs, sel_dmi;
    logic                dmi_upd, dmi_capt, hard_reset, dmi_reset;
    logic [1:0]          scan_op;

    always_comb begin
        tap_next = tap_state;
        case (tap_state)
            TLR:     tap_next = tms_i ? TLR    : RTI;
            RTI:     tap_next = tms_i ? SEL_DR : RTI;
            SEL_DR:  tap_next = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = tms_i ? EX1_DR : SH_DR;
            SH_DR:   tap_next = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = tms_i ? UPD_DR : PA_DR;
            PA_DR:   tap_next = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  tap_next = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  tap_next = tms_i ? SEL_DR : RTI;
            SEL_IR:  tap_next = tms_i ? TLR    : CAP_IR;
            CAP_IR:  tap_next = tms_i ? EX1_IR : SH_IR;
            SH_IR:   tap_next = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = tms_i ? UPD_IR : PA_IR;
            PA_IR:   tap_next = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  tap_next = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  tap_next = tms_i ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) tap_state <= TLR;
        else        tap_state <= tap_next;
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            ir    <= IR_IDCODE;
            ir_sr <= '0;
        end else begin
            case (tap_state)
                TLR:     ir    <= IR_IDCODE;
                CAP_IR:  ir_sr <= IR_WIDTH'(1);
                SH_IR:   ir_sr <= {tdi_i, ir_sr[IR_WIDTH-1:1]};
                UPD_IR:  ir    <= ir_sr;
                default: ;
            endcase
        end
    end

    assign sel_idcode = (ir == IR_IDCODE);
    assign sel_dtmcs  = (ir == IR_DTMCS);
    assign sel_dmi    = (ir == IR_DMI);

    assign dtmcs_cap = {17'd0, IDLE_CYCLES, sticky, 6'(ABITS), 4'd1};
    assign dmi_cap   = {req_addr_o, rdata, (dmi_state != DMI_IDLE) ? 2'd3 : sticky};

    // Unselected instructions fall through to a 1-bit bypass in dr[0].
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            dr <= '0;
        end else if (tap_state == CAP_DR) begin
            if (sel_dmi)         dr <= dmi_cap;
            else if (sel_idcode) dr <= DRW'(IDCODE_VAL);
            else if (sel_dtmcs)  dr <= DRW'(dtmcs_cap);
            else                 dr <= '0;
        end else if (tap_state == SH_DR) begin
            if (sel_dmi)                     dr        <= {tdi_i, dr[DRW-1:1]};
            else if (sel_idcode || sel_dtmcs) dr[31:0] <= {tdi_i, dr[31:1]};
            else                             dr[0]     <= tdi_i;
        end
    end

    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_o    <= (tap_state == SH_IR) ? ir_sr[0] : dr[0];
            tdo_oe_o <= (tap_state == SH_IR) || (tap_state == SH_DR);
        end
    end

    assign dmi_upd    = (tap_state == UPD_DR) && sel_dmi;
    assign dmi_capt   = (tap_state == CAP_DR) && sel_dmi;
    assign hard_reset = (tap_state == UPD_DR) && sel_dtmcs && dr[17];
    assign dmi_reset  = (tap_state == UPD_DR) && sel_dtmcs && dr[16];
    assign scan_op    = dr[1:0];

    // Sticky only ever climbs 0 -> 2 -> 3 until explicitly cleared.
    always_comb begin
        sticky_nxt = sticky;
        if (dmi_state == DMI_WAIT && resp_valid_i) begin
            if (resp_op_i == 2'd3)                        sticky_nxt = 2'd3;
            else if (resp_op_i == 2'd2 && sticky != 2'd3) sticky_nxt = 2'd2;
        end
        if (dmi_state != DMI_IDLE && (dmi_capt || dmi_upd)) sticky_nxt = 2'd3;
        if (dmi_reset || hard_reset)                        sticky_nxt = 2'd0;
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            dmi_state    <= DMI_IDLE;
            req_valid_o  <= 1'b0;
            resp_ready_o <= 1'b1;
            req_addr_o   <= '0;
            req_data_o   <= '0;
            req_op_o     <= '0;
            rdata        <= '0;
            sticky       <= '0;
        end else begin
            sticky <= sticky_nxt;
            if (hard_reset) begin
                dmi_state    <= DMI_IDLE;
                req_valid_o  <= 1'b0;
                resp_ready_o <= 1'b1;
            end else begin
                case (dmi_state)
                    DMI_IDLE: begin
                        if (dmi_upd && sticky == 2'd0 &&
                            (scan_op == 2'd1 || scan_op == 2'd2)) begin
                            req_addr_o   <= dr[DRW-1:34];
                            req_data_o   <= dr[33:2];
                            req_op_o     <= scan_op;
                            req_valid_o  <= 1'b1;
                            resp_ready_o <= 1'b0;
                            dmi_state    <= DMI_REQ;
                        end
                    end
                    DMI_REQ: begin
                        if (req_ready_i) begin
                            req_valid_o  <= 1'b0;
                            resp_ready_o <= 1'b1;
                            dmi_state    <= DMI_WAIT;
                        end
                    end
                    DMI_WAIT: begin
                        if (resp_valid_i) begin
                            rdata     <= resp_data_i;
                            dmi_state <= DMI_IDLE;
                        end
                    end
                    default: dmi_state <= DMI_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_dtm_tap.sv
// Bench for riscv_dtm_tap: JTAG scans driven at pin level, checked against a
// transaction-level model of the DTM (pending access, sticky status, last read data).
module tb_riscv_dtm_tap;

    localparam int ABITS    = 7;
    localparam int IR_WIDTH = 5;
    localparam int DRW      = ABITS + 34;
    localparam logic [31:0] IDCODE = 32'h0000_0001;
    localparam int IDLE     = 1;

    logic tck = 1'b0;
    logic trst, tms, tdi, tdo, tdo_oe;
    logic req_valid, resp_ready;
    logic [ABITS-1:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic [1:0]  dm_rop;

    always #5 tck = ~tck;

    riscv_dtm_tap #(.ABITS(ABITS), .IR_WIDTH(IR_WIDTH), .IDCODE_VAL(IDCODE), .IDLE_CYCLES(3'd1)) dut (
        .tck_i(tck), .trst_i(trst), .tms_i(tms), .tdi_i(tdi),
        .tdo_o(tdo), .tdo_oe_o(tdo_oe),
        .req_valid_o(req_valid), .req_ready_i(dm_ready),
        .req_addr_o(req_addr), .req_data_o(req_data), .req_op_o(req_op),
        .resp_valid_i(dm_ready), .resp_ready_o(resp_ready),
        .resp_data_i(dm_rdata), .resp_op_i(dm_rop)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int oe_cnt;
    logic [4:0] cur_ir;

    // model state
    logic             m_pend;
    int               m_sticky;
    logic [31:0]      m_rdata;
    logic [ABITS-1:0] m_addr;
    logic [31:0]      m_data;
    logic [1:0]       m_op;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_sticky = 0; m_rdata = '0; m_addr = '0; m_data = '0; m_op = '0;
    endtask

    task automatic model_complete();
        m_rdata = dm_rdata;
        if (dm_rop == 2'd3)                     m_sticky = 3;
        else if (dm_rop == 2'd2 && m_sticky != 3) m_sticky = 2;
        m_pend = 1'b0;
    endtask

    task automatic step(input logic t, input logic d);
        tms = t; tdi = d;
        @(posedge tck); @(negedge tck); #1;
        if (tdo_oe) oe_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic shift_ir(input logic [4:0] v);
        logic [63:0] out;
        out = '0;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < IR_WIDTH; i++) begin
            out[i] = tdo;
            step(i == IR_WIDTH - 1, v[i]);
        end
        step(1, 0); step(0, 0);
        check_eq("ir_capture", out, 64'd1);
        cur_ir = v;
    endtask

    task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        oe_cnt = 0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < len; i++) begin
            dout[i] = tdo;
            step(i == len - 1, din[i]);
        end
        step(1, 0); step(0, 0);
    endtask

    task automatic id_scan();
        logic [63:0] dout;
        scan_dr(32, {32'd0, $urandom}, dout);
        check_eq("idcode", dout, 64'(IDCODE));
        check_eq("oe_cycles", 64'(oe_cnt), 64'd32);
    endtask

    task automatic dmi_scan(input logic [1:0] op, input logic [ABITS-1:0] addr, input logic [31:0] data);
        logic [63:0] din, dout, exp_cap;
        logic [1:0]  cap_op;
        logic        issued;
        if (cur_ir != 5'h11) shift_ir(5'h11);
        din     = 64'({addr, data, op});
        cap_op  = m_pend ? 2'd3 : 2'(m_sticky);
        exp_cap = 64'({m_addr, m_rdata, cap_op});
        if (m_pend) m_sticky = 3;
        scan_dr(DRW, din, dout);
        check_eq("dmi_capture", dout, exp_cap);
        issued = 1'b0;
        if (m_pend) m_sticky = 3;
        else if (m_sticky == 0 && (op == 2'd1 || op == 2'd2)) begin
            issued = 1'b1; m_addr = addr; m_data = data; m_op = op;
        end
        check_eq("req_valid", 64'(req_valid), 64'(issued || m_pend));
        check_eq("resp_ready", 64'(resp_ready), 64'(!(issued || m_pend)));
        if (issued || m_pend) begin
            check_eq("req_addr", 64'(req_addr), 64'(m_addr));
            check_eq("req_data", 64'(req_data), 64'(m_data));
            check_eq("req_op", 64'(req_op), 64'(m_op));
        end
        if (issued) begin
            if (dm_ready) model_complete();
            else          m_pend = 1'b1;
        end
        idle(3);
        check_eq("req_valid_after", 64'(req_valid), 64'(m_pend));
    endtask

    task automatic dtmcs_scan(input logic [31:0] din);
        logic [63:0] dout, exp;
        if (cur_ir != 5'h10) shift_ir(5'h10);
        exp = 64'(1 + (ABITS << 4) + (m_sticky << 10) + (IDLE << 12));
        scan_dr(32, 64'(din), dout);
        check_eq("dtmcs_capture", dout, exp);
        if (din[17]) begin m_pend = 1'b0; m_sticky = 0; end
        if (din[16]) m_sticky = 0;
        check_eq("req_valid_dtmcs", 64'(req_valid), 64'(m_pend));
        idle(1);
    endtask

    task automatic bypass_scan(input logic [4:0] v);
        logic [63:0] din, dout;
        shift_ir(v);
        if (v == 5'h01) begin
            id_scan();
        end else begin
            din = 64'($urandom_range(0, 255));
            scan_dr(8, din, dout);
            check_eq("bypass", dout, (din << 1) & 64'hFF);
        end
    endtask

    task automatic release_dm(input logic [1:0] rop);
        dm_rdata = $urandom; dm_rop = rop; dm_ready = 1'b1;
        idle(3);
        if (m_pend) model_complete();
        check_eq("req_valid_release", 64'(req_valid), 64'd0);
    endtask

    function automatic logic [1:0] pick_rop();
        int r;
        r = $urandom_range(0, 3);
        if (r == 2) return 2'd2;
        if (r == 3) return 2'd3;
        return 2'd0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        trst = 1'b1; tms = 1'b1; tdi = 1'b0;
        dm_ready = 1'b1; dm_rdata = '0; dm_rop = '0;
        model_reset();
        cur_ir = 5'h01;
        #1;
        check_eq("rst_tdo", 64'(tdo), 64'd0);
        check_eq("rst_tdo_oe", 64'(tdo_oe), 64'd0);
        check_eq("rst_req_valid", 64'(req_valid), 64'd0);
        check_eq("rst_req_fields", 64'({req_addr, req_data, req_op}), 64'd0);
        check_eq("rst_resp_ready", 64'(resp_ready), 64'd1);
        @(negedge tck); @(negedge tck); #1;
        trst = 1'b0;
        step(0, 0);
        id_scan();

        dtmcs_scan(32'h0);
        dm_rdata = 32'hCAFE_0001; dm_rop = 2'd0;
        dmi_scan(2'd2, 7'h10, 32'h1);
        dmi_scan(2'd0, 7'h00, 32'h0);

        dm_ready = 1'b0;
        dmi_scan(2'd1, 7'h22, 32'h0);
        dmi_scan(2'd1, 7'h23, 32'h0);
        release_dm(2'd0);
        dmi_scan(2'd1, 7'h24, 32'h0);
        dtmcs_scan(32'h0001_0000);
        dmi_scan(2'd1, 7'h25, 32'h0);

        dm_rdata = 32'h1234_5678; dm_rop = 2'd2;
        dmi_scan(2'd1, 7'h30, 32'h0);
        dm_rop = 2'd0;
        dmi_scan(2'd1, 7'h31, 32'h0);
        dtmcs_scan(32'h0001_0000);
        dmi_scan(2'd0, 7'h00, 32'h0);

        dm_ready = 1'b0;
        dmi_scan(2'd2, 7'h40, 32'hA5A5_A5A5);
        dtmcs_scan(32'h0002_0000);
        release_dm(2'd0);
        dmi_scan(2'd0, 7'h00, 32'h0);

        bypass_scan(5'h1F);
        bypass_scan(5'h05);

        for (int it = 0; it < 60; it++) begin
            int act;
            logic [4:0] v;
            act = $urandom_range(0, 9);
            if (act <= 3) begin
                if (dm_ready) begin dm_rdata = $urandom; dm_rop = pick_rop(); end
                dmi_scan(2'($urandom_range(0, 3)), 7'($urandom), $urandom);
            end else if (act <= 5) begin
                dtmcs_scan($urandom);
            end else if (act == 6) begin
                dm_ready = 1'b0;
            end else if (act == 7) begin
                release_dm(pick_rop());
            end else if (act == 8) begin
                v = 5'($urandom_range(0, 31));
                if (v == 5'h10 || v == 5'h11) v = 5'h1F;
                bypass_scan(v);
            end else begin
                step(1, 0); step(1, 0); step(1, 0); step(1, 0); step(1, 0); step(0, 0);
                cur_ir = 5'h01;
                id_scan();
            end
        end

        dm_ready = 1'b0;
        dmi_scan(2'd1, 7'h55, 32'h0);
        trst = 1'b1;
        #2;
        check_eq("trst_req_valid", 64'(req_valid), 64'd0);
        check_eq("trst_resp_ready", 64'(resp_ready), 64'd1);
        check_eq("trst_req_addr", 64'(req_addr), 64'd0);
        @(negedge tck); #1;
        trst = 1'b0;
        model_reset();
        cur_ir = 5'h01;
        step(0, 0);
        release_dm(2'd3);
        dmi_scan(2'd0, 7'h00, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
